// File: rtl/kf_sched_pkg.sv
// Shared widths, FSM encoding and helpers for the kalman track scheduler.
package kf_sched_pkg;

   localparam int X_W = 192;
   localparam int P_W = 1152;
   localparam int Z_W = 128;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_WRITEBACK
   } sched_state_t;

   function automatic logic trk_ok(input int unsigned trk, input int unsigned num);
      return trk < num;
   endfunction

endpackage

// File: rtl/kf_rr_arbiter.sv
// Rotating-priority pick: first set request searching from last_served+1, wrapping.
module kf_rr_arbiter #(
   parameter int NUM_TRACKS = 4,
   parameter int TRK_W      = $clog2(NUM_TRACKS)
) (
   input  logic [NUM_TRACKS-1:0] req,
   input  logic [TRK_W-1:0]      last_served,
   output logic [TRK_W-1:0]      pick,
   output logic                  any_valid
);

   always_comb begin : search
      int idx;
      idx       = 0;
      pick      = '0;
      any_valid = 1'b0;
      // last_served itself is visited last, so a lone requester is always found
      for (int i = 1; i <= NUM_TRACKS; i++) begin
         idx = (int'(last_served) + i) % NUM_TRACKS;
         if (!any_valid && req[idx]) begin
            any_valid = 1'b1;
            pick      = TRK_W'(idx);
         end
      end
   end

endmodule

// File: rtl/kf_track_scheduler.sv
// Time-shares one kalman core among NUM_TRACKS tracks with per-track x/P bank.
// Optional WAIT watchdog (err_timeout, core_abort) enabled by KF_SCHED_TIMEOUT_EN.
module kf_track_scheduler
   import kf_sched_pkg::*;
#(
   parameter int NUM_TRACKS     = 4,
   parameter int TRK_W          = $clog2(NUM_TRACKS),
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       cfg_size_state,
   input  logic [2:0]       cfg_size_meas,
   input  logic             init_valid,
   output logic             init_ready,
   input  logic [TRK_W-1:0] init_track,
   input  logic [X_W-1:0]   init_x,
   input  logic [P_W-1:0]   init_P,
   input  logic             meas_valid,
   output logic             meas_ready,
   input  logic [TRK_W-1:0] meas_track,
   input  logic [Z_W-1:0]   meas_z,
   input  logic [TRK_W-1:0] rd_track,
   output logic [X_W-1:0]   rd_x,
   output logic [P_W-1:0]   rd_P,
   output logic             res_valid,
   output logic [TRK_W-1:0] res_track,
   output logic             err_bad_track,
   output logic             core_start,
   output logic [2:0]       core_size_state,
   output logic [2:0]       core_size_meas,
   output logic [X_W-1:0]   core_x,
   output logic [P_W-1:0]   core_P,
   output logic [Z_W-1:0]   core_z,
   input  logic [X_W-1:0]   core_x_out,
   input  logic [P_W-1:0]   core_P_out,
   input  logic             core_done,
   output logic             busy
`ifdef KF_SCHED_TIMEOUT_EN
  ,output logic             err_timeout,
   output logic             core_abort
`endif
);

   sched_state_t state, state_nxt;

   logic [X_W-1:0] bank_x [NUM_TRACKS];
   logic [P_W-1:0] bank_P [NUM_TRACKS];
   logic [Z_W-1:0] zbuf   [NUM_TRACKS];
   logic [NUM_TRACKS-1:0] pending;

   logic [TRK_W-1:0] cur_track, last_served, pick;
   logic any_pend, pick_fire;
   logic meas_ok, init_ok, meas_fire, init_fire;

   assign meas_ready = 1'b1;
   assign busy       = (state != S_IDLE);
   assign init_ready = !(busy && init_track == cur_track);
   assign res_track  = cur_track;

   assign meas_ok   = trk_ok(32'(meas_track), 32'(NUM_TRACKS));
   assign init_ok   = trk_ok(32'(init_track), 32'(NUM_TRACKS));
   assign meas_fire = meas_valid && meas_ok;
   assign init_fire = init_valid && init_ready && init_ok;

   kf_rr_arbiter #(.NUM_TRACKS(NUM_TRACKS), .TRK_W(TRK_W)) u_arb (
      .req         (pending),
      .last_served (last_served),
      .pick        (pick),
      .any_valid   (any_pend)
   );

`ifdef KF_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      core_start = 1'b0;
      res_valid  = 1'b0;
      pick_fire  = 1'b0;
`ifdef KF_SCHED_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (any_pend) begin
               pick_fire = 1'b1;
               state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            core_start = 1'b1;
            state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            if (core_done) state_nxt = S_WRITEBACK;
`ifdef KF_SCHED_TIMEOUT_EN
            else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               state_nxt   = S_IDLE;
            end
`endif
         end
         S_WRITEBACK: begin
            res_valid = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Launch snapshot: core operands stay stable for the whole service
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_track       <= '0;
         last_served     <= '0;
         core_x          <= '0;
         core_P          <= '0;
         core_z          <= '0;
         core_size_state <= '0;
         core_size_meas  <= '0;
      end else begin
         if (pick_fire) begin
            cur_track       <= pick;
            core_x          <= bank_x[pick];
            core_P          <= bank_P[pick];
            core_z          <= zbuf[pick];
            core_size_state <= cfg_size_state;
            core_size_meas  <= cfg_size_meas;
         end
         if (res_valid) last_served <= cur_track;
      end
   end

   // A measurement always beats the pick/init clear, so a same-cycle z is never lost
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         for (int i = 0; i < NUM_TRACKS; i++) begin
            bank_x[i] <= '0;
            bank_P[i] <= '0;
            zbuf[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_TRACKS; i++) begin
            if (res_valid && cur_track == TRK_W'(i)) begin
               bank_x[i] <= core_x_out;
               bank_P[i] <= core_P_out;
            end else if (init_fire && init_track == TRK_W'(i)) begin
               bank_x[i] <= init_x;
               bank_P[i] <= init_P;
            end
            if (meas_fire && meas_track == TRK_W'(i)) begin
               zbuf[i]    <= meas_z;
               pending[i] <= 1'b1;
            end else if ((pick_fire && pick == TRK_W'(i)) ||
                         (init_fire && init_track == TRK_W'(i))) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_bad_track <= 1'b0;
      else if ((meas_valid && !meas_ok) || (init_valid && init_ready && !init_ok))
         err_bad_track <= 1'b1;
   end

   always_comb begin
      rd_x = '0;
      rd_P = '0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
         if (rd_track == TRK_W'(i)) begin
            rd_x = bank_x[i];
            rd_P = bank_P[i];
         end
      end
   end

`ifdef KF_SCHED_TIMEOUT_EN
   // Registered abort so the core reset path sees a clean single-cycle pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
         core_abort  <= 1'b0;
      end else begin
         wait_cnt   <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
         core_abort <= timeout_hit;
         if (timeout_hit) err_timeout <= 1'b1;
      end
   end
`endif

endmodule
